row_rf_sched: RTL and testbench

- Controller for a bank of NUM_ROWS row register files feeding the PE array. Each row register file holds 4 x 64-bit words, is written per word, and streams one word per read cycle.
- Pops 64-bit words from the input FIFO and writes them into the row files in row-major order. It then broadcasts the 4-cycle read stream, waits for the PE array to finish, and releases the row files.
- Repeats for a programmed number of passes. Sits between the input FIFO and the row-file bank.

---
 rtl/row_rf_sched_pkg.sv | 22 ++
 rtl/row_rf_sched_if.sv | 45 ++++
 rtl/row_fill_cnt.sv | 56 +++++
 rtl/row_rf_sched.sv | 162 ++++++++++++++++
 tb/tb_row_rf_sched.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/row_rf_sched_pkg.sv
// -----------------------------------------------------------------------------
// row_rf_sched_pkg
// Shared types and constants for the row register-file scheduler.
//   state_t        : controller states, also exported on the debug port
//   WORDS_PER_ROW  : 64-bit words held by one row register file
//   STREAM_CYCLES  : length of the broadcast read stream
// -----------------------------------------------------------------------------
package row_rf_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    DRAIN   = 3'd2,
    STREAM  = 3'd3,
    WAIT_PE = 3'd4,
    RELEASE = 3'd5
  } state_t;

  localparam int WORDS_PER_ROW = 4;
  localparam int STREAM_CYCLES = 4;

endpackage

// File: rtl/row_rf_sched_if.sv
// -----------------------------------------------------------------------------
// row_rf_sched_if
// Bus between the scheduler, the input FIFO and the row-file bank.
//   fifo_empty    : FIFO has no word at its head
//   fifo_rdata    : FIFO head word (first-word fall-through)
//   fifo_pop      : consume the head word this cycle
//   rf_write_en   : one-hot row-file write enable
//   rf_write_addr : word address within the selected row
//   rf_write_data : word being written
//   rf_read_en    : broadcast read enable to every row file
//   rf_full_row   : broadcast release to every row file
// Modports: master = scheduler, slave = FIFO / row-file bank side.
//
// Handshake: the FIFO offers a word whenever fifo_empty is low (valid =
// !fifo_empty); the scheduler accepts it by raising fifo_pop (ready). A word
// transfers exactly in a cycle where fifo_pop is high, and fifo_pop is never
// raised while fifo_empty is high.
// -----------------------------------------------------------------------------
interface row_rf_sched_if #(
  parameter int NUM_ROWS = 4,
  parameter int DATA_W   = 64
);

  logic                fifo_empty;
  logic [DATA_W-1:0]   fifo_rdata;
  logic                fifo_pop;
  logic [NUM_ROWS-1:0] rf_write_en;
  logic [1:0]          rf_write_addr;
  logic [DATA_W-1:0]   rf_write_data;
  logic                rf_read_en;
  logic                rf_full_row;

  modport master (
    input  fifo_empty, fifo_rdata,
    output fifo_pop, rf_write_en, rf_write_addr, rf_write_data,
    output rf_read_en, rf_full_row
  );

  modport slave (
    output fifo_empty, fifo_rdata,
    input  fifo_pop, rf_write_en, rf_write_addr, rf_write_data,
    input  rf_read_en, rf_full_row
  );

endinterface

// File: rtl/row_fill_cnt.sv
// -----------------------------------------------------------------------------
// row_fill_cnt
// Row-major fill position for the row-file bank.
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : return to row 0 word 0 and drop the filled flag
//   adv         : one word was popped at the current position
//   fill_word   : word index within the current row (wraps 3 -> 0)
//   row_onehot  : one-hot decode of the current row
//   last_word   : current position is the final word of the last row
//   filled      : every word of the bank has been popped since the last clear
// -----------------------------------------------------------------------------
module row_fill_cnt
  import row_rf_sched_pkg::*;
#(
  parameter int NUM_ROWS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                adv,
  output logic [1:0]          fill_word,
  output logic [NUM_ROWS-1:0] row_onehot,
  output logic                last_word,
  output logic                filled
);

  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  logic [ROW_W-1:0] fill_row;

  assign last_word  = (fill_row == ROW_W'(NUM_ROWS - 1)) &&
                      (fill_word == 2'(WORDS_PER_ROW - 1));
  assign row_onehot = NUM_ROWS'(1) << fill_row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_word <= '0;
      fill_row  <= '0;
      filled    <= 1'b0;
    end else if (clear) begin
      fill_word <= '0;
      fill_row  <= '0;
      filled    <= 1'b0;
    end else if (adv) begin
      if (fill_word == 2'(WORDS_PER_ROW - 1)) begin
        fill_word <= '0;
        // Wrapping back to row 0 leaves the counters ready for the next pass.
        fill_row  <= last_word ? '0 : fill_row + 1'b1;
      end else begin
        fill_word <= fill_word + 1'b1;
      end
      if (last_word) filled <= 1'b1;
    end
  end

endmodule

// File: rtl/row_rf_sched.sv
// -----------------------------------------------------------------------------
// row_rf_sched
// Fills NUM_ROWS row register files from the input FIFO in row-major order,
// broadcasts a STREAM_CYCLES read stream, waits for the PE array, releases the
// row files, and repeats for num_passes passes.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : one-cycle pulse, latches num_passes (ignored while busy)
//   num_passes  : number of fill/stream passes
//   pe_done     : PE array consumed the current row set (counted in WAIT_PE)
//   busy        : run in progress
//   done        : one-cycle pulse after the final release
//   dbg_state   : current controller state
//   bus         : FIFO and row-file bank signals (master side)
// Optional build macro ROW_PREFETCH_EN: fill the next pass's words while
// waiting for the PE array (never on the last pass).
// -----------------------------------------------------------------------------
module row_rf_sched
  import row_rf_sched_pkg::*;
#(
  parameter int NUM_ROWS = 4,
  parameter int DATA_W   = 64,
  parameter int PASS_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PASS_W-1:0] num_passes,
  input  logic              pe_done,
  output logic              busy,
  output logic              done,
  output state_t            dbg_state,
  row_rf_sched_if.master    bus
);

  state_t              state;
  logic [PASS_W-1:0]   pass_cnt;
  logic [1:0]          stream_cnt;

  logic [1:0]          fill_word;
  logic [NUM_ROWS-1:0] row_onehot;
  logic                last_word;
  logic                filled;
  logic                cnt_clear;
  logic                prefetch_ok;
  logic                fill_active;
  logic                pop;

  assign dbg_state = state;

  // A pass starts either from IDLE or when the previously written words are
  // about to be streamed; after that point the row files may be refilled.
  assign cnt_clear = ((state == IDLE) && start && (num_passes != '0)) ||
                     (state == DRAIN);

`ifdef ROW_PREFETCH_EN
  // A pop in the pe_done cycle would land its write on the RELEASE cycle,
  // colliding with the broadcast read, so that cycle is skipped.
  assign prefetch_ok = (state == WAIT_PE) && !pe_done &&
                       (pass_cnt != PASS_W'(1));
`else
  assign prefetch_ok = 1'b0;
`endif

  assign fill_active  = (state == FILL) || prefetch_ok;
  assign pop          = fill_active && !filled && !bus.fifo_empty;
  assign bus.fifo_pop = pop;

  row_fill_cnt #(
    .NUM_ROWS (NUM_ROWS)
  ) u_fill_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .adv        (pop),
    .fill_word  (fill_word),
    .row_onehot (row_onehot),
    .last_word  (last_word),
    .filled     (filled)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      pass_cnt          <= '0;
      stream_cnt        <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      bus.rf_write_en   <= '0;
      bus.rf_write_addr <= '0;
      bus.rf_write_data <= '0;
      bus.rf_read_en    <= 1'b0;
      bus.rf_full_row   <= 1'b0;
    end else begin
      done            <= 1'b0;
      bus.rf_write_en <= pop ? row_onehot : '0;
      if (pop) begin
        bus.rf_write_addr <= fill_word;
        bus.rf_write_data <= bus.fifo_rdata;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (num_passes == '0) begin
              done <= 1'b1;
            end else begin
              state    <= FILL;
              busy     <= 1'b1;
              pass_cnt <= num_passes;
            end
          end
        end

        FILL: begin
          if (pop && last_word) state <= DRAIN;
        end

        // The final write of the fill is on the bus during this cycle.
        DRAIN: begin
          state          <= STREAM;
          stream_cnt     <= '0;
          bus.rf_read_en <= 1'b1;
        end

        STREAM: begin
          if (stream_cnt == 2'(STREAM_CYCLES - 1)) begin
            state          <= WAIT_PE;
            bus.rf_read_en <= 1'b0;
          end else begin
            stream_cnt <= stream_cnt + 1'b1;
          end
        end

        WAIT_PE: begin
          if (pe_done) begin
            state           <= RELEASE;
            bus.rf_read_en  <= 1'b1;
            bus.rf_full_row <= 1'b1;
          end
        end

        RELEASE: begin
          bus.rf_read_en  <= 1'b0;
          bus.rf_full_row <= 1'b0;
          pass_cnt        <= pass_cnt - 1'b1;
          if (pass_cnt == PASS_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (filled) begin
            state <= DRAIN;
          end else begin
            state <= FILL;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_rf_sched.sv
// -----------------------------------------------------------------------------
// tb_row_rf_sched
// Self-checking bench for row_rf_sched. A timeline model predicts, per cycle,
// pop / write / read / release / busy / done, and the ordered list of row-file
// writes, from the FIFO-empty schedule and the pe_done delays it chooses.
// -----------------------------------------------------------------------------
module tb_row_rf_sched;
  import row_rf_sched_pkg::*;

  localparam int NUM_ROWS = 4;
  localparam int DATA_W   = 64;
  localparam int PASS_W   = 8;
  localparam int TOT      = NUM_ROWS * WORDS_PER_ROW;
  localparam int W        = NUM_ROWS + 2 + DATA_W;
  localparam int MAXC     = 1024;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [PASS_W-1:0] num_passes;
  logic              pe_done;
  logic              busy;
  logic              done;
  state_t            dbg_state;

  row_rf_sched_if #(.NUM_ROWS(NUM_ROWS), .DATA_W(DATA_W)) bus ();

  row_rf_sched #(
    .NUM_ROWS (NUM_ROWS),
    .DATA_W   (DATA_W),
    .PASS_W   (PASS_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_passes (num_passes),
    .pe_done    (pe_done),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0]      exp_q[$];
  logic [W-1:0]      obs_q[$];
  logic              gap_s[MAXC];
  logic              pe_s[MAXC];
  logic              st_s[MAXC];
  logic [PASS_W-1:0] np_s[MAXC];
  logic [DATA_W-1:0] fifo_mem[MAXC];
  // bit order {pop, write, read, release, busy, done}
  logic [5:0]        e_vec[MAXC];
  logic [5:0]        o_vec[MAXC];
  int                rd_ptr;
  bit                pf_build;

  // ---------------- driver tasks ----------------
  task automatic prep(input bit seq_data, input int gap_pct);
    exp_q.delete();
    obs_q.delete();
    rd_ptr = 0;
    for (int c = 0; c < MAXC; c++) begin
      gap_s[c]    = ($urandom_range(0, 99) < gap_pct);
      pe_s[c]     = 1'b0;
      st_s[c]     = 1'b0;
      np_s[c]     = '0;
      e_vec[c]    = '0;
      o_vec[c]    = '0;
      fifo_mem[c] = seq_data ? DATA_W'(c + 1) : {$urandom, $urandom};
    end
  endtask

  // Drives cycle c's inputs just after the edge, records the DUT outputs on
  // the falling edge and lets the FIFO model advance on the popped word.
  task automatic drive(input int n);
    for (int c = 0; c < n; c++) begin
      start          = st_s[c];
      num_passes     = np_s[c];
      pe_done        = pe_s[c];
      bus.fifo_empty = gap_s[c];
      bus.fifo_rdata = fifo_mem[rd_ptr];
      @(negedge clk);
      o_vec[c] = {bus.fifo_pop, |bus.rf_write_en, bus.rf_read_en,
                  bus.rf_full_row, busy, done};
      if (|bus.rf_write_en)
        obs_q.push_back({bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data});
      if (bus.fifo_pop) rd_ptr++;
      @(posedge clk);
      #1;
    end
    start   = 1'b0;
    pe_done = 1'b0;
  endtask

  // ---------------- reference model ----------------
  task automatic expect_pop(input int c, input int idx, input int g);
    logic [NUM_ROWS-1:0] oh;
    oh = '0;
    oh[idx / WORDS_PER_ROW] = 1'b1;
    e_vec[c][5]   = 1'b1;
    e_vec[c+1][4] = 1'b1;
    exp_q.push_back({oh, 2'(idx % WORDS_PER_ROW), fifo_mem[g]});
  endtask

  // Start is sampled in cycle s. Fill pops whenever the FIFO is non-empty
  // until the bank holds TOT words; the cycle after the last pop presents the
  // last write, then STREAM_CYCLES read cycles, then the PE wait. The release
  // cycle follows the pe_done cycle; the next pass (or done) follows that.
  task automatic build_model(input int s, input int passes, input int min_dly,
                             input int max_dly, input bit spur, output int done_c);
    int t, cnt, g, se, w, r;
    cnt = 0;
    g   = 0;
    t   = s + 1;
    if (passes == 0) begin
      e_vec[s+1][0] = 1'b1;
      done_c = s + 1;
    end else begin
      for (int p = 0; p < passes; p++) begin
        while (cnt < TOT && t < MAXC - 64) begin
          if (!gap_s[t]) begin
            expect_pop(t, cnt, g);
            cnt++;
            g++;
          end else if (spur && $urandom_range(0, 2) == 0) begin
            pe_s[t] = 1'b1;
          end
          t++;
        end
        se = t + 1 + STREAM_CYCLES;
        for (int c = t + 1; c < se; c++) e_vec[c][3] = 1'b1;
        cnt = 0;
        w = se + $urandom_range(min_dly, max_dly);
        pe_s[w] = 1'b1;
        if (pf_build && p != passes - 1) begin
          for (int c = se; c < w; c++) begin
            if (cnt < TOT && !gap_s[c]) begin
              expect_pop(c, cnt, g);
              cnt++;
              g++;
            end
          end
        end
        r = w + 1;
        e_vec[r][3] = 1'b1;
        e_vec[r][2] = 1'b1;
        t = r + 1;
      end
      e_vec[t][0] = 1'b1;
      for (int c = s + 1; c < t; c++) e_vec[c][1] = 1'b1;
      done_c = t;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.fifo_pop, bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data,
         bus.rf_read_en, bus.rf_full_row, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got pop=%b we=%b wa=%0d wd=%h re=%b fr=%b busy=%b done=%b, want all 0",
               bus.fifo_pop, bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data,
               bus.rf_read_en, bus.rf_full_row, busy, done);
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_pass();
    int done_c, pops;
    prep(1'b1, 0);
    st_s[1] = 1'b1;
    np_s[1] = PASS_W'(1);
    build_model(1, 1, 0, 6, 1'b0, done_c);
    drive(done_c + 4);
    pops = 0;
    for (int c = 0; c < done_c + 4; c++) begin
      pops += int'(o_vec[c][5]);
      n_cmp++;
      if (o_vec[c] !== e_vec[c]) begin
        n_err++;
        $display("FAIL single_pass cyc %0d pop/we/re/fr/busy/done: got %b want %b", c, o_vec[c], e_vec[c]);
      end
    end
    n_cmp++;
    if (pops != TOT) begin
      n_err++;
      $display("FAIL single_pass pop_count: got %0d want %0d", pops, TOT);
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL single_pass write_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL single_pass write %0d {we,addr,data}: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_fifo_stall();
    int done_c;
    prep(1'b1, 0);
    st_s[1] = 1'b1;
    np_s[1] = PASS_W'(1);
    // words 1..6 pop in cycles 2..7, then the FIFO runs dry for 5 cycles
    for (int c = 8; c < 13; c++) gap_s[c] = 1'b1;
    build_model(1, 1, 0, 3, 1'b0, done_c);
    drive(done_c + 4);
    for (int c = 0; c < done_c + 4; c++) begin
      n_cmp++;
      if (o_vec[c] !== e_vec[c]) begin
        n_err++;
        $display("FAIL fifo_stall cyc %0d pop/we/re/fr/busy/done: got %b want %b", c, o_vec[c], e_vec[c]);
      end
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL fifo_stall write_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL fifo_stall write %0d {we,addr,data}: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_multi_pass();
    int done_c;
    prep(1'b0, 20);
    st_s[1] = 1'b1;
    np_s[1] = PASS_W'(3);
    // a second start while busy must not disturb the run
    st_s[6] = 1'b1;
    np_s[6] = PASS_W'(5);
    build_model(1, 3, 0, 8, 1'b1, done_c);
    drive(done_c + 4);
    for (int c = 0; c < done_c + 4; c++) begin
      n_cmp++;
      if (o_vec[c] !== e_vec[c]) begin
        n_err++;
        $display("FAIL multi_pass cyc %0d pop/we/re/fr/busy/done: got %b want %b", c, o_vec[c], e_vec[c]);
      end
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL multi_pass write_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL multi_pass write %0d {we,addr,data}: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_passes();
    int done_c;
    prep(1'b1, 0);
    st_s[1] = 1'b1;
    np_s[1] = '0;
    build_model(1, 0, 0, 0, 1'b0, done_c);
    drive(done_c + 6);
    for (int c = 0; c < done_c + 6; c++) begin
      n_cmp++;
      if (o_vec[c] !== e_vec[c]) begin
        n_err++;
        $display("FAIL zero_passes cyc %0d pop/we/re/fr/busy/done: got %b want %b", c, o_vec[c], e_vec[c]);
      end
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL zero_passes write_count: got %0d want 0", obs_q.size());
    end
  endtask

  task automatic test_reset_mid_stream();
    int done_c;
    prep(1'b1, 0);
    st_s[1] = 1'b1;
    np_s[1] = PASS_W'(1);
    build_model(1, 1, 0, 4, 1'b0, done_c);
    // pops 2..17, last write 18, reads 19..22: stop driving at read cycle 2
    drive(20);
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if (o_vec[c] !== e_vec[c]) begin
        n_err++;
        $display("FAIL reset_mid cyc %0d pop/we/re/fr/busy/done: got %b want %b", c, o_vec[c], e_vec[c]);
      end
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.fifo_pop, bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data,
         bus.rf_read_en, bus.rf_full_row, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got pop=%b we=%b wa=%0d wd=%h re=%b fr=%b busy=%b done=%b, want all 0",
               bus.fifo_pop, bus.rf_write_en, bus.rf_write_addr, bus.rf_write_data,
               bus.rf_read_en, bus.rf_full_row, busy, done);
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_mid_state: got %0d want %0d", dbg_state, IDLE);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.fifo_pop, bus.rf_read_en, busy, done} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_mid_quiet %0d pop/re/busy/done: got %b want 0000", k,
                 {bus.fifo_pop, bus.rf_read_en, busy, done});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int done_c, passes, pct;
    for (int it = 0; it < 4; it++) begin
      passes = $urandom_range(1, 3);
      pct    = $urandom_range(0, 40);
      prep(1'b0, pct);
      st_s[1] = 1'b1;
      np_s[1] = PASS_W'(passes);
      build_model(1, passes, 0, 20, 1'b1, done_c);
      drive(done_c + 4);
      for (int c = 0; c < done_c + 4; c++) begin
        n_cmp++;
        if (o_vec[c] !== e_vec[c]) begin
          n_err++;
          $display("FAIL random it%0d cyc %0d pop/we/re/fr/busy/done: got %b want %b", it, c, o_vec[c], e_vec[c]);
        end
      end
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
        n_err++;
        $display("FAIL random it%0d write_count: got %0d want %0d", it, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL random it%0d write %0d {we,addr,data}: got %h want %h", it, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

`ifdef ROW_PREFETCH_EN
  // PE wait long enough for the whole next pass to be prefetched, so the
  // second pass goes straight from release through one drain cycle to reads.
  task automatic test_prefetch();
    int done_c;
    prep(1'b1, 0);
    st_s[1] = 1'b1;
    np_s[1] = PASS_W'(2);
    build_model(1, 2, TOT + 2, TOT + 4, 1'b0, done_c);
    drive(done_c + 4);
    for (int c = 0; c < done_c + 4; c++) begin
      n_cmp++;
      if (o_vec[c] !== e_vec[c]) begin
        n_err++;
        $display("FAIL prefetch cyc %0d pop/we/re/fr/busy/done: got %b want %b", c, o_vec[c], e_vec[c]);
      end
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL prefetch write_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL prefetch write %0d {we,addr,data}: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
`ifdef ROW_PREFETCH_EN
    pf_build = 1'b1;
`else
    pf_build = 1'b0;
`endif
    rst            = 1'b1;
    start          = 1'b0;
    pe_done        = 1'b0;
    num_passes     = '0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rdata = '0;

    test_reset();
    test_single_pass();
    test_fifo_stall();
    test_multi_pass();
    test_zero_passes();
    test_reset_mid_stream();
    test_random();
`ifdef ROW_PREFETCH_EN
    test_prefetch();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
